cipher_frame_sequencer: RTL and testbench
=========================================

# cipher_frame_sequencer

Upstream framing stage for the byte-wide stream cipher. It accepts framed bytes from a host over a valid/ready byte stream. Each frame is a key byte, a length byte, N payload bytes and, optionally, a checksum byte. It converts each frame into the cipher's control sequence: a one-cycle key-load strobe, then one data strobe per payload byte. The cipher restarts its counter at every frame because of that key load.

## Interface

- Parameters: none. Widths are fixed: 8-bit bytes, 8-bit length.
- Ports:
  - clk  in  1  clock
  - rst_n  in  1  reset, asynchronous, active-low
  - s_data  in  8  host byte
  - s_valid  in  1  host byte valid
  - s_ready  out  1  block accepts s_data this cycle
  - abort  in  1  synchronous frame abort
  - key  out  8  key value to cipher
  - key_in  out  1  one-cycle key-load strobe to cipher
  - din  out  8  payload byte to cipher
  - din_valid  out  1  payload strobe to cipher
  - busy  out  1  frame in progress (state not IDLE)
  - frame_done  out  1  one-cycle pulse, frame completed
  - chk_err  out  1  one-cycle pulse, checksum mismatch (FRAME_CHECKSUM_EN only, else tied 0)

## Operation

- Handshake: a byte is accepted when s_valid && s_ready on a rising clk edge.
- s_ready = (state != DONE) && !abort. The cipher never backpressures, so there is no other stall source.
- FSM states are IDLE, LEN, DATA, CHK, DONE.
  - IDLE: an accepted byte is the key. Go to LEN.
  - LEN: the accepted byte loads remaining count rem = byte.
    - If byte == 0: go to CHK (macro on) or DONE (macro off).
    - Otherwise go to DATA.
  - DATA: each accepted byte is payload; rem decrements.
    - When the byte accepted with rem == 1 arrives: go to CHK (macro on) or DONE (macro off).
  - CHK: the accepted byte is compared with the running XOR of the payload. Go to DONE.
  - DONE: lasts exactly one cycle with s_ready = 0, then IDLE.
- Gaps in s_valid are allowed in any state. No strobe is produced in a cycle without an accepted byte.
- key_in and din_valid are never asserted in the same cycle.
- Length range is 0..255.
  - rem is 8 bits. It never wraps, because DATA is left at rem == 1.
  - Length 0 produces a key load with no din_valid strobes.
- abort takes priority over everything:
  - The next state is IDLE and rem clears.
  - The byte presented in the abort cycle is not accepted.
  - No frame_done or chk_err pulse is generated.
  - Strobes already registered from the previous cycle still complete.
- Reset is legal mid-frame. It returns to IDLE with all outputs at reset values, and any partial frame is discarded.

## Timing

- Reset values: s_ready 0 while rst_n low, 1 from the first edge after release; key 8'h00; key_in 0; din 8'h00; din_valid 0; busy 0; frame_done 0; chk_err 0.
- All outputs except s_ready are registered. Latency is 1 cycle from acceptance.
  - Key byte accepted at edge T: key = byte and key_in = 1 for the cycle after T. key holds its value until the next key byte.
  - Payload byte accepted at T: din = byte and din_valid = 1 for the cycle after T. din holds when din_valid = 0.
- frame_done asserts in the cycle after the final byte is accepted, coincident with the last din_valid when there is no trailer.
  - Final byte means: the last payload byte, the length byte when length is 0, or the checksum byte when the macro is on.
- chk_err asserts coincident with frame_done.
- Throughput: one byte per cycle within a frame. There is one dead cycle (DONE) between frames.

## Configuration

- FRAME_CHECKSUM_EN defined:
  - CHK state exists and an 8-bit XOR accumulator runs over the payload, cleared in IDLE.
  - The trailer byte is required.
  - chk_err pulses when trailer != XOR.
  - Payload strobes are still issued regardless of chk_err.
- Undefined:
  - No CHK state, no accumulator.
  - chk_err is tied 0.
  - Frame is key + length + payload only.

## Structure

- Shared package cipher_pkg holds:
  - the state enum (IDLE, LEN, DATA, CHK, DONE);
  - localparam BYTE_W = 8;
  - the key reset constant 8'h00.
- No sub-module: the FSM, the rem counter and the XOR accumulator stay flat in one module.

## Test plan

- Basic frame: key 8'h3C, length 8'h03, payload 8'h11, 8'h22, 8'h33 on consecutive cycles -> key_in one cycle with key = 8'h3C, then din_valid for 3 cycles with din 8'h11, 8'h22, 8'h33, frame_done with the last; s_ready 0 for one cycle after.
- Empty frame: key 8'hA5, length 8'h00 -> one key_in, zero din_valid, frame_done one cycle after the length byte.
- Max length with gaps: length 8'hFF, s_valid toggling 1/0 -> exactly 255 din_valid pulses in order, no wrap, then back to IDLE.
- Abort: abort high after 2 of 5 payload bytes -> s_ready 0 that cycle, no frame_done, busy 0 next cycle; a following frame encodes normally.
- Checksum (FRAME_CHECKSUM_EN): payload 8'h0F, 8'hF0 with trailer 8'hFF -> frame_done, chk_err 0. Same payload with trailer 8'h00 -> frame_done and chk_err together.
- Reset mid-frame: rst_n low during DATA -> all outputs at reset values immediately; after release a new key byte is accepted as a key.

Source files
------------

// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared types and constants for the cipher framing stage
package cipher_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] KEY_RST = 8'h00;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/cipher_frame_sequencer.sv
// rtl/cipher_frame_sequencer.sv - frames host bytes into key-load/data strobes for the stream cipher
// Optional checksum trailer: FRAME_CHECKSUM_EN
module cipher_frame_sequencer
    import cipher_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              abort,
    output logic [BYTE_W-1:0] key,
    output logic              key_in,
    output logic [BYTE_W-1:0] din,
    output logic              din_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              chk_err
);

    state_t            state_q;
    logic [BYTE_W-1:0] rem_q;
    logic [BYTE_W-1:0] rem_d;
    logic [BYTE_W-1:0] key_q;
    logic [BYTE_W-1:0] din_q;
    logic              key_in_q;
    logic              din_valid_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              ready_en_q;
    logic              accept;

`ifdef FRAME_CHECKSUM_EN
    logic [BYTE_W-1:0] acc_q;
    logic              chk_err_q;
`endif

    // ready_en_q keeps s_ready low until the first edge after reset release
    assign s_ready = ready_en_q && (state_q != DONE) && !abort;
    assign accept  = s_valid && s_ready;
    assign rem_d   = rem_q - 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            key_q        <= KEY_RST;
            din_q        <= '0;
            key_in_q     <= 1'b0;
            din_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            ready_en_q   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            acc_q        <= '0;
            chk_err_q    <= 1'b0;
`endif
        end else begin
            ready_en_q   <= 1'b1;
            key_in_q     <= 1'b0;
            din_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            chk_err_q    <= 1'b0;
`endif
            if (abort) begin
                state_q <= IDLE;
                rem_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
`ifdef FRAME_CHECKSUM_EN
                        acc_q <= '0;
`endif
                        if (accept) begin
                            key_q    <= s_data;
                            key_in_q <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= LEN;
                        end
                    end
                    LEN: begin
                        if (accept) begin
                            rem_q <= s_data;
                            if (s_data == '0) begin
`ifdef FRAME_CHECKSUM_EN
                                state_q <= CHK;
`else
                                state_q      <= DONE;
                                frame_done_q <= 1'b1;
`endif
                            end else begin
                                state_q <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            din_q       <= s_data;
                            din_valid_q <= 1'b1;
                            rem_q       <= rem_d;
`ifdef FRAME_CHECKSUM_EN
                            acc_q <= acc_q ^ s_data;
`endif
                            // Leaving at rem == 1 keeps the 8-bit counter from wrapping
                            if (rem_q == 8'd1) begin
`ifdef FRAME_CHECKSUM_EN
                                state_q <= CHK;
`else
                                state_q      <= DONE;
                                frame_done_q <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef FRAME_CHECKSUM_EN
                    CHK: begin
                        if (accept) begin
                            frame_done_q <= 1'b1;
                            chk_err_q    <= (s_data != acc_q);
                            state_q      <= DONE;
                        end
                    end
`endif
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign key        = key_q;
    assign key_in     = key_in_q;
    assign din        = din_q;
    assign din_valid  = din_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
`ifdef FRAME_CHECKSUM_EN
    assign chk_err    = chk_err_q;
`else
    assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cipher_frame_sequencer.sv
// tb/tb_cipher_frame_sequencer.sv - directed self-checking bench for cipher_frame_sequencer
// Checksum scenarios are compiled in with FRAME_CHECKSUM_EN
module tb_cipher_frame_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       abort;
    logic [7:0] key;
    logic       key_in;
    logic [7:0] din;
    logic       din_valid;
    logic       busy;
    logic       frame_done;
    logic       chk_err;

    int checks   = 0;
    int failures = 0;

    cipher_frame_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .abort      (abort),
        .key        (key),
        .key_in     (key_in),
        .din        (din),
        .din_valid  (din_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .chk_err    (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    // Present a byte for one edge, return 1 time unit after that edge
    task automatic drive(input logic [7:0] d, input logic v);
        s_data  = d;
        s_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; abort = 1'b0;
        #3;
        checks++;
        if (s_ready !== 1'b0 || key !== 8'h00 || key_in !== 1'b0 || din !== 8'h00 ||
            din_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || chk_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got rdy=%b key=%h kin=%b din=%h dv=%b busy=%b fd=%b ce=%b want all zero",
                     s_ready, key, key_in, din, din_valid, busy, frame_done, chk_err);
        end
        #9 rst_n = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready got %b want 0", s_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_edge got rdy=%b busy=%b want 1/0", s_ready, busy);
        end
    endtask

    task automatic test_basic();
        drive(8'h3C, 1'b1);
        checks++;
        if (key_in !== 1'b1 || key !== 8'h3C || din_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_key got kin=%b key=%h dv=%b busy=%b want 1/3c/0/1", key_in, key, din_valid, busy);
        end
        drive(8'h03, 1'b1);
        checks++;
        if (key_in !== 1'b0 || din_valid !== 1'b0 || key !== 8'h3C) begin
            failures++;
            $display("FAIL basic_len got kin=%b dv=%b key=%h want 0/0/3c", key_in, din_valid, key);
        end
        drive(8'h11, 1'b1);
        checks++;
        if (din_valid !== 1'b1 || din !== 8'h11 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_d0 got dv=%b din=%h fd=%b want 1/11/0", din_valid, din, frame_done);
        end
        drive(8'h22, 1'b1);
        checks++;
        if (din_valid !== 1'b1 || din !== 8'h22 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_d1 got dv=%b din=%h fd=%b want 1/22/0", din_valid, din, frame_done);
        end
        drive(8'h33, 1'b1);
`ifdef FRAME_CHECKSUM_EN
        checks++;
        if (din_valid !== 1'b1 || din !== 8'h33 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_d2 got dv=%b din=%h fd=%b want 1/33/0", din_valid, din, frame_done);
        end
        drive(8'h00, 1'b1);
        checks++;
        if (frame_done !== 1'b1 || chk_err !== 1'b0 || din_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_trailer got fd=%b ce=%b dv=%b want 1/0/0", frame_done, chk_err, din_valid);
        end
`else
        checks++;
        if (din_valid !== 1'b1 || din !== 8'h33 || frame_done !== 1'b1 || chk_err !== 1'b0) begin
            failures++;
            $display("FAIL basic_d2 got dv=%b din=%h fd=%b ce=%b want 1/33/1/0", din_valid, din, frame_done, chk_err);
        end
`endif
        s_valid = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_done_cycle got rdy=%b busy=%b want 0/1", s_ready, busy);
        end
        drive(8'h00, 1'b0);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || din !== 8'h33) begin
            failures++;
            $display("FAIL basic_idle got rdy=%b busy=%b fd=%b din=%h want 1/0/0/33", s_ready, busy, frame_done, din);
        end
    endtask

    task automatic test_empty();
        drive(8'hA5, 1'b1);
        checks++;
        if (key_in !== 1'b1 || key !== 8'hA5) begin
            failures++;
            $display("FAIL empty_key got kin=%b key=%h want 1/a5", key_in, key);
        end
        drive(8'h00, 1'b1);
`ifdef FRAME_CHECKSUM_EN
        drive(8'h00, 1'b1);
`endif
        checks++;
        if (frame_done !== 1'b1 || din_valid !== 1'b0 || key_in !== 1'b0 || chk_err !== 1'b0) begin
            failures++;
            $display("FAIL empty_done got fd=%b dv=%b kin=%b ce=%b want 1/0/0/0", frame_done, din_valid, key_in, chk_err);
        end
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);
        checks++;
        if (busy !== 1'b0 || din_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_idle got busy=%b dv=%b want 0/0", busy, din_valid);
        end
    endtask

    task automatic test_max_len();
        int         pulses = 0;
        int         bad    = 0;
        logic [7:0] x      = 8'h00;
        drive(8'h5A, 1'b1);
        drive(8'hFF, 1'b1);
        for (int i = 0; i < 255; i++) begin
            logic [7:0] b;
            b = 8'(i * 7 + 3);
            x = x ^ b;
            drive(b, 1'b1);
            if (din_valid === 1'b1) pulses++;
            if (din_valid !== 1'b1 || din !== b) bad++;
`ifdef FRAME_CHECKSUM_EN
            if (frame_done !== 1'b0) bad++;
`else
            if (frame_done !== (i == 254)) bad++;
`endif
            drive(8'hEE, 1'b0);
            if (din_valid !== 1'b0 || frame_done !== 1'b0) bad++;
        end
`ifdef FRAME_CHECKSUM_EN
        drive(x, 1'b1);
        checks++;
        if (frame_done !== 1'b1 || chk_err !== 1'b0) begin
            failures++;
            $display("FAIL maxlen_trailer got fd=%b ce=%b want 1/0", frame_done, chk_err);
        end
`endif
        checks++;
        if (pulses != 255 || bad != 0) begin
            failures++;
            $display("FAIL maxlen_stream got pulses=%0d bad=%0d want 255/0", pulses, bad);
        end
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL maxlen_idle got busy=%b rdy=%b want 0/1", busy, s_ready);
        end
    endtask

    task automatic test_abort();
        drive(8'h77, 1'b1);
        drive(8'h05, 1'b1);
        drive(8'h01, 1'b1);
        drive(8'h02, 1'b1);
        abort  = 1'b1;
        s_data = 8'h03;
        #1;
        checks++;
        if (s_ready !== 1'b0 || din_valid !== 1'b1 || din !== 8'h02) begin
            failures++;
            $display("FAIL abort_cycle got rdy=%b dv=%b din=%h want 0/1/02", s_ready, din_valid, din);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || din_valid !== 1'b0 || frame_done !== 1'b0 || chk_err !== 1'b0) begin
            failures++;
            $display("FAIL abort_after got busy=%b dv=%b fd=%b ce=%b want 0/0/0/0", busy, din_valid, frame_done, chk_err);
        end
        drive(8'h12, 1'b1);
        checks++;
        if (key_in !== 1'b1 || key !== 8'h12) begin
            failures++;
            $display("FAIL abort_next_key got kin=%b key=%h want 1/12", key_in, key);
        end
        drive(8'h01, 1'b1);
        drive(8'h9A, 1'b1);
`ifdef FRAME_CHECKSUM_EN
        checks++;
        if (din_valid !== 1'b1 || din !== 8'h9A) begin
            failures++;
            $display("FAIL abort_next_data got dv=%b din=%h want 1/9a", din_valid, din);
        end
        drive(8'h9A, 1'b1);
        checks++;
        if (frame_done !== 1'b1 || chk_err !== 1'b0) begin
            failures++;
            $display("FAIL abort_next_done got fd=%b ce=%b want 1/0", frame_done, chk_err);
        end
`else
        checks++;
        if (din_valid !== 1'b1 || din !== 8'h9A || frame_done !== 1'b1) begin
            failures++;
            $display("FAIL abort_next_data got dv=%b din=%h fd=%b want 1/9a/1", din_valid, din, frame_done);
        end
`endif
        drive(8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        drive(8'hB1, 1'b1);
        drive(8'h00, 1'b1);
`ifdef FRAME_CHECKSUM_EN
        drive(8'h00, 1'b1);
`endif
        drive(8'hB2, 1'b1);
        checks++;
        if (key_in !== 1'b0 || key !== 8'hB1) begin
            failures++;
            $display("FAIL b2b_done_gap got kin=%b key=%h want 0/b1", key_in, key);
        end
        drive(8'hB2, 1'b1);
        checks++;
        if (key_in !== 1'b1 || key !== 8'hB2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_key got kin=%b key=%h busy=%b want 1/b2/1", key_in, key, busy);
        end
        drive(8'h00, 1'b1);
`ifdef FRAME_CHECKSUM_EN
        drive(8'h00, 1'b1);
`endif
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b0);
    endtask

`ifdef FRAME_CHECKSUM_EN
    task automatic test_checksum();
        drive(8'h01, 1'b1);
        drive(8'h02, 1'b1);
        drive(8'h0F, 1'b1);
        drive(8'hF0, 1'b1);
        drive(8'hFF, 1'b1);
        checks++;
        if (frame_done !== 1'b1 || chk_err !== 1'b0) begin
            failures++;
            $display("FAIL chk_good got fd=%b ce=%b want 1/0", frame_done, chk_err);
        end
        drive(8'h00, 1'b0);
        drive(8'h01, 1'b1);
        drive(8'h02, 1'b1);
        drive(8'h0F, 1'b1);
        drive(8'hF0, 1'b1);
        checks++;
        if (din_valid !== 1'b1 || din !== 8'hF0) begin
            failures++;
            $display("FAIL chk_bad_payload got dv=%b din=%h want 1/f0", din_valid, din);
        end
        drive(8'h00, 1'b1);
        checks++;
        if (frame_done !== 1'b1 || chk_err !== 1'b1) begin
            failures++;
            $display("FAIL chk_bad got fd=%b ce=%b want 1/1", frame_done, chk_err);
        end
        drive(8'h00, 1'b0);
        checks++;
        if (chk_err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL chk_pulse got ce=%b busy=%b want 0/0", chk_err, busy);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        drive(8'h44, 1'b1);
        drive(8'h04, 1'b1);
        drive(8'h55, 1'b1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0 || key !== 8'h00 || key_in !== 1'b0 || din !== 8'h00 ||
            din_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || chk_err !== 1'b0) begin
            failures++;
            $display("FAIL midreset_values got rdy=%b key=%h kin=%b din=%h dv=%b busy=%b fd=%b ce=%b want all zero",
                     s_ready, key, key_in, din, din_valid, busy, frame_done, chk_err);
        end
        #2;
        s_data  = 8'hC3;
        s_valid = 1'b1;
        rst_n   = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b1 || key_in !== 1'b0) begin
            failures++;
            $display("FAIL midreset_release got rdy=%b kin=%b want 1/0", s_ready, key_in);
        end
        drive(8'hC3, 1'b1);
        checks++;
        if (key_in !== 1'b1 || key !== 8'hC3 || din_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_newkey got kin=%b key=%h dv=%b want 1/c3/0", key_in, key, din_valid);
        end
        drive(8'h00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_max_len();
        test_abort();
        test_back_to_back();
`ifdef FRAME_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
